// File: rtl/sb_pkg.sv
// Shared sizes and types for the register pending-write scoreboard.
// Latency: n/a (package only); backpressure: n/a.
package sb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int SB_CNT_W   = 2;

    typedef logic [NUM_REGS-1:0][SB_CNT_W-1:0] cnt_vec_t;
endpackage

// File: rtl/sb_counter.sv
// One register's in-flight write counter with saturation and error flag.
// Latency: count updates on the next clk edge; backpressure: none, every event is applied.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec_wb,
    input  logic             dec_kill,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             err
);
    localparam logic signed [CNT_W+1:0] MAX_CNT = $signed({2'b00, {CNT_W{1'b1}}});

    logic signed [CNT_W+1:0] sum;
    logic        [CNT_W-1:0] count_d;

    // Two extra bits hold both +max overflow and the -2 worst case without wrapping.
    always_comb begin
        sum = $signed({2'b00, count})
            + $signed({{(CNT_W+1){1'b0}}, inc})
            - $signed({{(CNT_W+1){1'b0}}, dec_wb})
            - $signed({{(CNT_W+1){1'b0}}, dec_kill});
        count_d = sum[CNT_W-1:0];
        err     = 1'b0;
        if (sum < 0) begin
            count_d = '0;
            err     = 1'b1;
        end else if (sum > MAX_CNT) begin
            count_d = '1;
            err     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else      count <= count_d;
    end

    assign nonzero = |count;
endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracker driving the ID-stage freeze.
// Latency: pending/sb_err one cycle after an event, hazard combinational; backpressure: none.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int CNT_W     = SB_CNT_W,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_wb_en,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  kill_valid,
    input  logic [REG_ADDR_W-1:0] kill_dest,
    input  logic [REG_ADDR_W-1:0] src1_ID,
    input  logic [REG_ADDR_W-1:0] src2_ID,
    input  logic                  is_imm,
    output logic                  hazard_detected,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  sb_err
);
    logic [CNT_W-1:0]    count [NUM_REGS];
    logic [NUM_REGS-1:0] err;

    // r0 is never written, so it has no counter and can never raise an error.
    assign count[0]   = '0;
    assign pending[0] = 1'b0;
    assign err[0]     = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic inc, dec_wb, dec_kill;
        assign inc      = issue_valid & issue_wb_en & (issue_dest == REG_ADDR_W'(r));
        assign dec_wb   = wb_valid   & (wb_dest   == REG_ADDR_W'(r));
        assign dec_kill = kill_valid & (kill_dest == REG_ADDR_W'(r));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc),
            .dec_wb   (dec_wb),
            .dec_kill (dec_kill),
            .count    (count[r]),
            .nonzero  (pending[r]),
            .err      (err[r])
        );
    end

    // A last outstanding write landing this cycle is already visible through the write-first RF.
    function automatic logic src_hazard(input logic [CNT_W-1:0]      cnt,
                                        input logic [REG_ADDR_W-1:0] src,
                                        input logic                  wv,
                                        input logic [REG_ADDR_W-1:0] wd);
        logic bypass;
        bypass = WB_BYPASS && wv && (wd == src) && (cnt == CNT_W'(1));
        return (src != '0) && (cnt != '0) && !bypass;
    endfunction

    always_comb begin
        hazard_detected = src_hazard(count[src1_ID], src1_ID, wb_valid, wb_dest)
                        | (~is_imm & src_hazard(count[src2_ID], src2_ID, wb_valid, wb_dest));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      sb_err <= 1'b0;
        else if (|err) sb_err <= 1'b1;
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard with a reference count model and expectation queue.
module tb_reg_scoreboard;
    import sb_pkg::*;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0, issue_wb_en = 1'b0;
    logic [4:0]  issue_dest = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic        kill_valid = 1'b0;
    logic [4:0]  kill_dest = '0;
    logic [4:0]  src1_ID = '0, src2_ID = '0;
    logic        is_imm = 1'b0;
    logic        hazard_detected;
    logic [31:0] pending;
    logic        sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          haz;
        logic [31:0] pend;
        bit          err;
    } exp_t;

    exp_t q[$];
    int   mc[32];
    bit   merr;

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_wb_en     (issue_wb_en),
        .issue_dest      (issue_dest),
        .wb_valid        (wb_valid),
        .wb_dest         (wb_dest),
        .kill_valid      (kill_valid),
        .kill_dest       (kill_dest),
        .src1_ID         (src1_ID),
        .src2_ID         (src2_ID),
        .is_imm          (is_imm),
        .hazard_detected (hazard_detected),
        .pending         (pending),
        .sb_err          (sb_err)
    );

    function automatic bit mhaz(input logic [4:0] s, input bit wv, input logic [4:0] wd);
        if (s == 0 || mc[s] == 0) return 1'b0;
        if (wv && wd == s && mc[s] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) mc[r] = 0;
        merr = 1'b0;
    endtask

    // Drive one cycle, push the model's expectation, and return just before the rising edge.
    task automatic cyc(input bit iv, input bit ie, input logic [4:0] id,
                       input bit wv, input logic [4:0] wd,
                       input bit kv, input logic [4:0] kd,
                       input logic [4:0] s1, input logic [4:0] s2, input bit imm);
        exp_t e;
        int   n;
        @(negedge clk);
        issue_valid = iv; issue_wb_en = ie; issue_dest = id;
        wb_valid = wv; wb_dest = wd; kill_valid = kv; kill_dest = kd;
        src1_ID = s1; src2_ID = s2; is_imm = imm;
        e.haz = mhaz(s1, wv, wd) | (!imm & mhaz(s2, wv, wd));
        for (int r = 1; r < 32; r++) begin
            n = mc[r] + int'(iv && ie && id == r) - int'(wv && wd == r) - int'(kv && kd == r);
            if (n < 0) begin n = 0; merr = 1'b1; end
            else if (n > MAXC) begin n = MAXC; merr = 1'b1; end
            mc[r] = n;
        end
        e.pend = '0;
        for (int r = 1; r < 32; r++) e.pend[r] = (mc[r] != 0);
        e.err = merr;
        q.push_back(e);
        #3;
    endtask

    task automatic idle(input logic [4:0] s1, input logic [4:0] s2, input bit imm);
        cyc(0, 0, 0, 0, 0, 0, 0, s1, s2, imm);
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #3;
        if (q.size() > 0) begin
            e = q[0];
            n_tests++;
            if (hazard_detected !== e.haz) begin
                n_fail++;
                $display("FAIL sb_hazard t=%0t: got %b want %b", $time, hazard_detected, e.haz);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (pending !== e.pend || sb_err !== e.err) begin
                n_fail++;
                $display("FAIL sb_state t=%0t: pending=%h err=%b want pending=%h err=%b",
                         $time, pending, sb_err, e.pend, e.err);
            end
            void'(q.pop_front());
        end
    end

    // Asynchronous reset pulse between edges; state must clear without waiting for a clock.
    task automatic test_mid_reset_pulse(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (pending !== 32'h0 || hazard_detected !== 1'b0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_async_clear: pending=%h haz=%b err=%b want 0/0/0",
                     tag, pending, hazard_detected, sb_err);
        end
        #1;
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        model_clear();
        #3;
        src1_ID = 5; src2_ID = 6; is_imm = 1'b0;
        #1;
        n_tests++;
        if (hazard_detected !== 1'b0 || pending !== 32'h0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: haz=%b pending=%h err=%b want 0/0/0",
                     hazard_detected, pending, sb_err);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_issue_wb();
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        idle(5, 0, 0);
        n_tests++;
        if (hazard_detected !== 1'b1 || pending[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_visible: haz=%b pend5=%b want 1/1", hazard_detected, pending[5]);
        end
        idle(5, 0, 0);
        cyc(0, 0, 0, 1, 5, 0, 0, 5, 0, 0);
        n_tests++;
        if (hazard_detected !== 1'b0 || pending[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_bypass: haz=%b pend5=%b want 0/1", hazard_detected, pending[5]);
        end
        idle(5, 0, 0);
        n_tests++;
        if (pending[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_pending_clear: pend5=%b want 0", pending[5]);
        end
    endtask

    task automatic test_double_issue();
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 7, 1);
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 7, 1);
        n_tests++;
        if (hazard_detected !== 1'b0) begin
            n_fail++;
            $display("FAIL imm_src2_ignored: haz=%b want 0", hazard_detected);
        end
        cyc(0, 0, 0, 1, 7, 0, 0, 7, 0, 0);
        n_tests++;
        if (hazard_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL two_inflight_no_bypass: haz=%b want 1", hazard_detected);
        end
        idle(0, 7, 0);
        n_tests++;
        if (hazard_detected !== 1'b1 || pending[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL one_left: haz=%b pend7=%b want 1/1", hazard_detected, pending[7]);
        end
        cyc(0, 0, 0, 1, 7, 0, 0, 7, 0, 0);
        n_tests++;
        if (hazard_detected !== 1'b0) begin
            n_fail++;
            $display("FAIL last_wb_bypass: haz=%b want 0", hazard_detected);
        end
        idle(0, 7, 1);
    endtask

    task automatic test_same_cycle();
        cyc(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 9, 1, 9, 0, 0, 9, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 9, 9, 0, 0);
        n_tests++;
        if (pending[9] !== 1'b1 || hazard_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_wb_same_cycle: pend9=%b haz=%b want 1/1", pending[9], hazard_detected);
        end
        idle(9, 0, 0);
        n_tests++;
        if (pending[9] !== 1'b0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_release: pend9=%b err=%b want 0/0", pending[9], sb_err);
        end
        cyc(1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 10, 1, 10, 10, 0, 0);
        idle(10, 0, 0);
        n_tests++;
        if (pending[10] !== 1'b0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_kill_double_dec: pend10=%b err=%b want 0/0", pending[10], sb_err);
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 4; i++) cyc(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        idle(3, 0, 0);
        n_tests++;
        if (sb_err !== 1'b1 || pending[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: err=%b pend3=%b want 1/1", sb_err, pending[3]);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 3, 0, 0, 3, 0, 0);
        idle(3, 0, 0);
        n_tests++;
        if (sb_err !== 1'b1 || pending[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky_after_drain: err=%b pend3=%b want 1/0", sb_err, pending[3]);
        end
        test_mid_reset_pulse("ovf");
        cyc(0, 0, 0, 1, 12, 0, 0, 12, 0, 0);
        idle(12, 0, 0);
        n_tests++;
        if (sb_err !== 1'b1 || pending[12] !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow: err=%b pend12=%b want 1/0", sb_err, pending[12]);
        end
        test_mid_reset_pulse("unf");
        cyc(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 6, 0, 0, 0, 0, 0, 0, 0);
        idle(6, 0, 0);
        n_tests++;
        if (pending !== 32'h0 || sb_err !== 1'b0 || hazard_detected !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_and_nowb_ignored: pending=%h err=%b haz=%b want 0/0/0",
                     pending, sb_err, hazard_detected);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        idle(4, 0, 0);
        n_tests++;
        if (hazard_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_haz: haz=%b want 1", hazard_detected);
        end
        test_mid_reset_pulse("mid");
        cyc(1, 1, 4, 0, 0, 0, 0, 4, 0, 0);
        idle(4, 0, 0);
        n_tests++;
        if (pending !== 32'h0000_0010 || hazard_detected !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_issue: pending=%h haz=%b want 00000010/1", pending, hazard_detected);
        end
        cyc(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
                $urandom_range(0, 4) == 0, 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1));
            if (i == 200) test_mid_reset_pulse("rand");
        end
        idle(0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_issue_wb();
        test_double_issue();
        test_same_cycle();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Per-register pending-write tracker for the 5-stage MIPS pipeline. It records destination registers as instructions issue from ID into EXE and releases them at writeback or when a squash kills them. Its `hazard_detected` output tells ID to freeze, derived from registered in-flight counts instead of comparing stage destinations. It sits beside the ID stage and feeds the existing freeze/flush logic.

## Interface
- `CNT_W`, 2: width of each per-register in-flight counter. Maximum count is 2^CNT_W−1.
- `WB_BYPASS`, 1: 1 means a writeback in the current cycle satisfies a same-cycle read, matching the write-first register file.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `issue_valid` input 1: an instruction leaves ID into EXE this cycle.
- `issue_wb_en` input 1: the issuing instruction writes the register file.
- `issue_dest` input 5: destination of the issuing instruction.
- `wb_valid` input 1: WB stage writes the register file this cycle.
- `wb_dest` input 5: WB destination.
- `kill_valid` input 1: the EXE instruction is squashed this cycle and its write is cancelled.
- `kill_dest` input 5: destination of the squashed instruction.
- `src1_ID` input 5: ID source register 1.
- `src2_ID` input 5: ID source register 2.
- `is_imm` input 1: `src2_ID` is unused.
- `hazard_detected` output 1: ID must freeze.
- `pending` output 32: bit r is 1 when count[r] ≠ 0. Registered.
- `sb_err` output 1: sticky overflow/underflow flag. Registered.

## Operation
- State: 32 counters `count[r]`, each CNT_W bits wide. `count[0]` is hard-wired to 0.
- Increment event for r: `issue_valid & issue_wb_en & issue_dest==r & r!=0`.
- Decrement event for r: `wb_valid & wb_dest==r`, or `kill_valid & kill_dest==r`. Both events are counted separately, so up to 2 decrements per register per cycle.
- Next count per register: count + inc − dec, evaluated in CNT_W+2-bit signed arithmetic.
  - Result < 0: count is forced to 0 and `sb_err` is set.
  - Result > max: count holds at max and `sb_err` is set.
- `sb_err` stays set until reset.
- Any event targeting r0 is ignored and never sets `sb_err`.
- Hazard for source s: `s!=0 & eff[s]!=0`.
  - `eff[s]` = count[s] − 1 when `WB_BYPASS` is 1, `wb_valid`, `wb_dest==s` and count[s]==1.
  - Otherwise `eff[s]` = count[s].
- `hazard_detected` = hazard(src1_ID) | (~is_imm & hazard(src2_ID)).
  - Combinational from registered counts and the current-cycle wb inputs.
  - Issue and kill in the current cycle do not affect it.
- `issue_valid` asserted while `hazard_detected` is high is legal. The block counts it anyway; gating issue is the controller's job.

## Timing
- Reset (rst=0, asynchronous): all counts 0, `pending`=0, `sb_err`=0. `hazard_detected` is then 0 for any sources.
- Issue at edge N: `pending[r]` and the hazard for r are visible in cycle N+1.
- Writeback in cycle N: with bypass, the hazard for r clears in cycle N. Without bypass, it clears in N+1. `pending[r]` clears in N+1.
- Simultaneous issue and wb to the same r: count unchanged. A count of 1 stays 1.
- Simultaneous wb and kill to the same r with count 2: count becomes 0.
- Reset asserted mid-operation discards all in-flight state immediately. No event is replayed after release.

## Structure
- Shared package `sb_pkg`: `REG_ADDR_W`=5, `NUM_REGS`=32, default `CNT_W`, and a typedef for the counter vector.
- Sub-module `sb_counter`:
  - One per register, r=1..31.
  - Inputs: inc, dec_wb, dec_kill.
  - Outputs: count, nonzero, err.
  - Top level does address decode, hazard muxing and the OR-reduction of err.

## Test plan
- Reset, then query src1=5, src2=6, is_imm=0 → `hazard_detected`=0, `pending`=0, `sb_err`=0.
- Issue dest=5 at cycle 1; query src1=5 in cycle 2 → hazard=1, `pending[5]`=1. wb dest=5 in cycle 4 → hazard=0 in cycle 4 (bypass), `pending[5]`=0 in cycle 5.
- Issue dest=7 twice on consecutive cycles, then one wb of 7 → hazard stays 1, count=1. Second wb → hazard 0. Query src2=7 with is_imm=1 → hazard 0 throughout.
- Same-cycle issue and wb of dest=9 with count 1 → count stays 1, `pending[9]` stays 1. Kill dest=9 in the next cycle → `pending[9]`=0 one cycle later.
- Issue dest=3 four times with CNT_W=2 → count saturates at 3, `sb_err`=1 and stays 1. Separately, wb dest=12 with count 0 → `sb_err`=1, count stays 0. Issue dest=0 → no pending, no error.
- With dest=4 pending, pulse rst low between clock edges → `pending`=0 and hazard=0 immediately. Issue after release behaves as from reset.
